// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage: registered in_ready/out_valid, strict FIFO order, synchronous flush.
// Optional back-pressure statistics counter enabled by defining PIPE_STAGE_STALL_STATS_EN.
module pipe_stage_skid #(
    parameter int               WIDTH  = 143,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [15:0]      stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] main_data, main_next;
    logic [WIDTH-1:0] skid_data, skid_next;
    logic             accept, drain;

    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;
    assign out_data = main_data;

    always_comb begin
        state_next = state;
        main_next  = main_data;
        skid_next  = skid_data;
        case (state)
            EMPTY: begin
                if (accept) begin
                    main_next  = in_data;
                    state_next = ONE;
                end
            end
            ONE: begin
                case ({accept, drain})
                    2'b10: begin
                        skid_next  = in_data;
                        state_next = TWO;
                    end
                    2'b01:   state_next = EMPTY;
                    2'b11:   main_next  = in_data;
                    default: state_next = ONE;
                endcase
            end
            TWO: begin
                // in_ready is low here, so the only possible event is a drain
                if (drain) begin
                    main_next  = skid_data;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (clear) begin
            state_next = EMPTY;
            main_next  = BUBBLE;
            skid_next  = BUBBLE;
        end
    end

    // Handshake flags are registered from the next state so neither port has a combinational input path
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= BUBBLE;
            skid_data <= BUBBLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            main_data <= main_next;
            skid_data <= skid_next;
            in_ready  <= (state_next != TWO);
            out_valid <= (state_next != EMPTY);
        end
    end

`ifdef PIPE_STAGE_STALL_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // Counter survives clear on purpose; only rst returns it to zero
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= 16'd0;
        else if (out_valid && !out_ready)
            stall_cnt <= sat_inc(stall_cnt);
    end
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a two-slot FIFO queue model predicts handshakes, data order and stall count.
module tb_pipe_stage_skid;
    localparam int WIDTH = 143;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [15:0]      stall_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit armed = 1'b0;

    logic [WIDTH-1:0] sb_q[$];
    logic [15:0]      stall_exp = 16'd0;
    bit               hold_prev = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    pipe_stage_skid #(.WIDTH(WIDTH), .BUBBLE('0)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: checks the DUT against the queue model, then advances the model for the coming edge
    always @(negedge clk) begin : monitor
        int n;
        n = sb_q.size();
        if (armed) begin
            chk("out_valid", WIDTH'(out_valid), WIDTH'(n != 0));
            chk("in_ready", WIDTH'(in_ready), WIDTH'(n < 2));
            if (n != 0) chk("out_data", out_data, sb_q[0]);
            if (hold_prev) chk("stable", out_data, prev_data);
            chk("stall_cnt", WIDTH'(stall_cnt), WIDTH'(stall_exp));
        end
        hold_prev = armed && out_valid && !out_ready && !clear && !rst;
        prev_data = out_data;
        if (rst) begin
            sb_q.delete();
            stall_exp = 16'd0;
        end else begin
`ifdef PIPE_STAGE_STALL_STATS_EN
            if (n != 0 && !out_ready && stall_exp != 16'hFFFF) stall_exp = stall_exp + 16'd1;
`endif
            if (clear) sb_q.delete();
            else begin
                if (n != 0 && out_ready) void'(sb_q.pop_front());
                if (in_valid && n < 2) sb_q.push_back(in_data);
            end
        end
    end

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
    endtask

    function automatic logic [WIDTH-1:0] rand_data();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[WIDTH-1:0];
    endfunction

    initial begin
        logic [15:0] sat_val;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
        chk("reset_out_valid", WIDTH'(out_valid), WIDTH'(1'b0));
        chk("reset_stall", WIDTH'(stall_cnt), WIDTH'(16'd0));

        // Streaming 1,2,3 with downstream always ready
        drive(1'b1, WIDTH'(1), 1'b1, 1'b0);
        drive(1'b1, WIDTH'(2), 1'b1, 1'b0);
        drive(1'b1, WIDTH'(3), 1'b1, 1'b0);
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

        // Back-pressure fills the skid entry
        drive(1'b1, WIDTH'(8'hA5), 1'b0, 1'b0);
        drive(1'b1, WIDTH'(8'h5A), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_in_ready", WIDTH'(in_ready), WIDTH'(1'b0));
        repeat (4) drive(1'b0, '0, 1'b1, 1'b0);

        // Flush from TWO with a colliding input
        drive(1'b1, WIDTH'(1), 1'b0, 1'b0);
        drive(1'b1, WIDTH'(2), 1'b0, 1'b0);
        drive(1'b1, WIDTH'(8'h77), 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_out_valid", WIDTH'(out_valid), WIDTH'(1'b0));
        chk("flush_in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
        repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 10000; i++)
            drive(1'($urandom_range(0, 1)), rand_data(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 63) == 0));
        repeat (4) drive(1'b0, '0, 1'b1, 1'b0);

        // Long stall to reach counter saturation
        drive(1'b1, WIDTH'(8'h42), 1'b0, 1'b0);
        repeat (70000) drive(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_STALL_STATS_EN
        sat_val = 16'hFFFF;
`else
        sat_val = 16'h0000;
`endif
        @(negedge clk);
        chk("stall_saturated", WIDTH'(stall_cnt), WIDTH'(sat_val));
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("stall_after_clear", WIDTH'(stall_cnt), WIDTH'(sat_val));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("stall_after_rst", WIDTH'(stall_cnt), WIDTH'(16'd0));
        repeat (2) drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter WIDTH, default 143, meaning payload width in bits (instruction 32 + ctrl_msg 15 + alu 32 + A 32 + B 32).
REQ-002 The block SHALL have parameter BUBBLE, default 0, meaning the WIDTH-bit value loaded into payload registers on reset or flush.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port clear  input  1  synchronous flush; discards all held entries.
REQ-006 The block SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 The block SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 The block SHALL have port in_ready  output  1  block can accept in_data this cycle.
REQ-009 The block SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-010 The block SHALL have port out_data  output  WIDTH  oldest held payload.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 The block SHALL have port stall_cnt  output  16  downstream back-pressure cycle count.
REQ-013 The interface SHALL be fixed as: one clock; reset is synchronous and active-high, on ports clk and rst.

Function
REQ-014 Storage SHALL be two WIDTH-bit entries, main and skid; out_data SHALL come from main directly, with no combinational path from in_data.
REQ-015 in_ready SHALL be a register output, 1 exactly when skid is empty; out_valid SHALL be a register output.
REQ-016 Transfers SHALL occur on posedge clk: accept = in_valid & in_ready; drain = out_valid & out_ready.
REQ-017 States SHALL be EMPTY (no entries), ONE (main valid), and TWO (main and skid valid).
REQ-018 In EMPTY, accept SHALL move data to main and go to ONE; otherwise the state SHALL hold.
REQ-019 In ONE, accept without drain SHALL move data to skid and go to TWO.
REQ-020 In ONE, drain without accept SHALL go to EMPTY.
REQ-021 In ONE, accept with drain SHALL load main with in_data and stay in ONE.
REQ-022 In ONE, no accept and no drain SHALL hold.
REQ-023 In TWO, drain SHALL move skid to main and go to ONE; accept is impossible because in_ready is 0.
REQ-024 Latency SHALL be 1 cycle from accept in EMPTY to out_valid=1; sustained throughput SHALL be 1 per cycle with out_ready held at 1.
REQ-025 Ordering SHALL be strict FIFO; no payload SHALL be duplicated or dropped except by clear or rst.
REQ-026 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-027 clear=1 SHALL set the state to EMPTY, load main and skid with BUBBLE, set out_valid=0 and set in_ready=1 on the next cycle.
REQ-028 When clear coincides with accept and/or drain, clear SHALL win; the input is discarded, and the drain is still considered taken downstream.
REQ-029 When out_valid=0, out_data SHALL equal BUBBLE or the last drained value; consumers qualify it with out_valid.

Reset
REQ-030 When rst=1 at posedge, the block SHALL set state=EMPTY, out_valid=0, in_ready=1, main=skid=BUBBLE and stall_cnt=0.
REQ-031 rst SHALL take priority over clear and over all handshakes.
REQ-032 rst asserted mid-transfer SHALL discard all entries without producing an output transfer.
REQ-033 No initial blocks SHALL be relied on for reset values.

Configuration
REQ-034 With macro PIPE_STAGE_STALL_STATS_EN defined, stall_cnt SHALL increment each cycle where out_valid=1 and out_ready=0.
REQ-035 With PIPE_STAGE_STALL_STATS_EN defined, stall_cnt SHALL saturate at 16'hFFFF and clear only on rst, not on clear.
REQ-036 Without PIPE_STAGE_STALL_STATS_EN, stall_cnt SHALL be constant 0, no counter logic SHALL be synthesised, and the port SHALL remain present.

Verification
REQ-037 A bench SHALL cover: rst, then in_valid=1 with data 1,2,3 on consecutive cycles and out_ready=1 -> out_data 1,2,3 on cycles 1-3 after first accept, in_ready stays 1.
REQ-038 A bench SHALL cover: out_ready=0, push A5, then 5A -> in_ready=0 after the second accept; then out_ready=1 -> out_data A5 then 5A, and in_ready returns to 1.
REQ-039 A bench SHALL cover: TWO state, clear=1 with in_valid=1 data 77 -> next cycle out_valid=0, in_ready=1, 77 never appears on the output.
REQ-040 A bench SHALL cover: random in_valid/out_ready over 10000 cycles -> output sequence equals input sequence, no stable-data violation.
REQ-041 A bench SHALL cover: macro defined, out_valid=1 with out_ready=0 for 70000 cycles -> stall_cnt=FFFF; after clear it stays FFFF, after rst it reads 0.
REQ-042 A bench SHALL cover: macro undefined, same stimulus as REQ-041 -> stall_cnt=0 throughout.
